// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and data ports of the core.
// Define ARB_LOADER_PORT_EN to add a highest-priority write-only loader port.
module mem_port_arbiter #(
    parameter int unsigned SIZE         = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_valid,
    output logic [SIZE-1:0]       i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [SIZE-1:0]       d_wdata,
    output logic                  d_gnt,
    output logic                  d_valid,
    output logic [SIZE-1:0]       d_rdata,
`ifdef ARB_LOADER_PORT_EN
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [SIZE-1:0]       ld_wdata,
    output logic                  ld_gnt,
`endif
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [SIZE-1:0]       mem_wdata,
    input  logic [SIZE-1:0]       mem_rdata
);

    localparam int unsigned CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [SIZE-1:0]  i_hold_q, d_hold_q;
    logic             ld_win, d_win, i_win, starved;

    assign starved = (STARVE_LIMIT != 0) && (starve_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        ld_win = 1'b0;
`ifdef ARB_LOADER_PORT_EN
        ld_win = ld_req;
`endif
        // Data normally beats fetch; a starved fetch takes one cycle from data.
        d_win = !ld_win && d_req && !(starved && i_req);
        i_win = !ld_win && i_req && !d_win;
    end

    always_comb begin
        i_gnt     = i_win && RESET_N;
        d_gnt     = d_win && RESET_N;
        mem_en    = (ld_win || d_win || i_win) && RESET_N;
        mem_we    = (ld_win || (d_win && d_we)) && RESET_N;
        mem_addr  = d_win ? d_addr : i_addr;
        mem_wdata = d_wdata;
`ifdef ARB_LOADER_PORT_EN
        ld_gnt = ld_win && RESET_N;
        if (ld_win) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
`endif
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (d_win) begin
            owner_d = OWN_D;
        end else if (i_win) begin
            owner_d = OWN_I;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (ld_win) begin
            starve_d = starve_q;
        end else if (!i_req || i_win) begin
            starve_d = '0;
        end else if (starve_q != CNT_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    assign i_valid = (owner_q == OWN_I);
    assign d_valid = (owner_q == OWN_D);
    assign i_rdata = i_valid ? mem_rdata : i_hold_q;
    assign d_rdata = d_valid ? mem_rdata : d_hold_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            owner_q  <= OWN_NONE;
            starve_q <= '0;
            i_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            if (owner_q == OWN_I) begin
                i_hold_q <= mem_rdata;
            end
            if (owner_q == OWN_D) begin
                d_hold_q <= mem_rdata;
            end
        end
    end

endmodule
